eth_ipv4_hdr_parser: RTL and testbench
======================================

Name: eth_ipv4_hdr_parser

Overview:
- Downstream consumer of the 64-bit Avalon-ST packet stream produced by the pcap reader.
- Extracts the Ethernet II and IPv4 header fields from each packet and emits one header descriptor per packet on a valid/ready interface.
- Discards payload bytes, counts packet bytes and keeps packet and drop statistics.
- Sits between the stimulus source and the parser/NoC injection logic in the pkt_parser design.

Parameters:
- LEN_W, 16, width of the byte-length field; saturates at all-ones.
- CNT_W, 32, width of the statistics counters; wraps.

Ports:
- clk  in  1  sole clock.
- system_reset_n  in  1  asynchronous, active-low reset.
- in_data  in  64  packet bytes; byte k of the beat is in_data[63-8k -: 8].
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_sop  in  1  first beat of packet.
- in_eop  in  1  last beat of packet.
- in_empty  in  3  unused bytes on the eop beat (LSB end).
- in_error  in  1  beat error flag.
- desc_valid  out  1  descriptor valid.
- desc_ready  in  1  descriptor consumer ready.
- desc  out  packed hdr_desc_t  dst_mac[48], src_mac[48], ethertype[16], ip_proto[8], ip_src[32], ip_dst[32], pkt_len[LEN_W], is_ipv4, truncated, err.
- pkt_count  out  CNT_W  descriptors accepted by the consumer.
- drop_count  out  CNT_W  packets aborted by a sop arriving mid-packet.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; desc_valid=0; desc=0; counters=0; in_ready=1.
- in_ready = !desc_valid || desc_ready, combinational. The whole input stalls while an undelivered descriptor is held.
- A beat counts only when in_valid && in_ready.
- Bytes per beat: 8 if !in_eop, otherwise 8-in_empty.
- pkt_len accumulates these bytes and saturates at 2^LEN_W-1.
- FSM states and transitions:
  - IDLE: beats without sop are dropped silently (not counted). A sop beat loads beat 0 and goes to HDR with beat index=1. A sop beat with eop finishes immediately.
  - HDR: beat index 1..4. Header field capture by packet byte offset:
    - bytes 0-5 dst_mac
    - 6-11 src_mac
    - 12-13 ethertype
    - 14 ver/ihl
    - 23 ip_proto
    - 26-29 ip_src
    - 30-33 ip_dst
    - The capture is a fixed byte map for beats 0-4; only IHL=5 offsets are honoured, and options are treated as payload.
    - After beat 4 with no eop, go to BODY.
  - BODY: count bytes until eop.
  - Any state, eop accepted: load the descriptor register, assert desc_valid the next cycle, return to IDLE. Latency from eop beat to desc_valid is 1 cycle.
  - HDR or BODY, sop without preceding eop: drop the partial packet (no descriptor), increment drop_count, and treat this beat as beat 0 of the new packet.
- Descriptor flags:
  - is_ipv4 = (ethertype==0x0800) && (ver==4) && (pkt_len>=34).
  - truncated = pkt_len<34 (unsent header fields are 0).
  - err = OR of in_error over all accepted beats of the packet.
- Descriptor handshake: desc holds stable while desc_valid && !desc_ready. On desc_valid && desc_ready, pkt_count increments.
- Same-cycle desc handshake and eop: the new descriptor loads and desc_valid stays 1.
- Reset mid-packet: abandon all state, no descriptor, counters cleared.

Decomposition:
- Shared package pkt_parser_pkg:
  - hdr_desc_t packed struct
  - ETHERTYPE_IPV4=16'h0800
  - IPV4_MIN_HDR_END=34
  - beat byte-width constant BEAT_BYTES=8
  - state enum {IDLE,HDR,BODY}
- One sub-module, hdr_byte_capture: given beat index and in_data, writes the mapped header bytes. It is purely combinational-select plus the field registers.

Test Plan:
- 60-byte IPv4/UDP frame, dst=00:11:22:33:44:55, src=66:77:88:99:AA:BB, proto=0x11, ip_src=10.0.0.1, ip_dst=10.0.0.2, 8 beats (last empty=4) -> one descriptor 1 cycle after eop: fields match, pkt_len=60, is_ipv4=1, truncated=0, err=0.
- 64-byte ARP frame (ethertype 0x0806) -> is_ipv4=0, ethertype=0x0806, pkt_len=64.
- 20-byte frame, ethertype 0x0800, 3 beats (empty=4) -> truncated=1, is_ipv4=0, ip_src=0, pkt_len=20.
- Hold desc_ready=0 across two back-to-back packets -> in_ready drops after the first descriptor, desc stays stable, second packet stalls. After release, pkt_count=2 and no beats are lost.
- Three beats without eop, then a new sop packet of 40 bytes -> drop_count=1, single descriptor with pkt_len=40.
- Beat 2 with in_error=1; assert system_reset_n=0 mid-packet on a later run -> first run gives err=1. The reset run shows desc_valid=0 and counters=0 immediately, with no descriptor emitted after release.

Source files
------------

// File: rtl/pkt_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkt_parser_pkg
// Brief    : Shared types and constants for the Ethernet/IPv4 header parser.
// Revision : 1.0 - initial release
// ============================================================================
package pkt_parser_pkg;

    localparam int          BEAT_BYTES       = 8;
    localparam int          DESC_LEN_W       = 16;
    localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
    localparam int          IPV4_MIN_HDR_END = 34;
    localparam int          HDR_SLOTS        = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } parser_state_t;

    typedef struct packed {
        logic [47:0]           dst_mac;
        logic [47:0]           src_mac;
        logic [15:0]           ethertype;
        logic [7:0]            ip_proto;
        logic [31:0]           ip_src;
        logic [31:0]           ip_dst;
        logic [DESC_LEN_W-1:0] pkt_len;
        logic                  is_ipv4;
        logic                  truncated;
        logic                  err;
    } hdr_desc_t;

    // Packet byte offset held by each capture slot: bytes 0..14, 23, 26..33.
    function automatic int hdr_slot_offset(input int slot);
        if (slot <= 14) begin
            return slot;
        end else if (slot == 15) begin
            return 23;
        end else begin
            return slot + 10;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdr_byte_capture.sv
`default_nettype none
// ============================================================================
// Module   : hdr_byte_capture
// Brief    : Fixed byte-map capture of the Ethernet/IPv4 header fields.
// Revision : 1.0 - initial release
// ============================================================================
module hdr_byte_capture
    import pkt_parser_pkg::*;
(
    input  logic        clk,
    input  logic        system_reset_n,
    input  logic        cap_start,
    input  logic        cap_en,
    input  logic [2:0]  beat_idx,
    input  logic [3:0]  beat_bytes,
    input  logic [63:0] in_data,
    output logic [47:0] dst_mac_next,
    output logic [47:0] src_mac_next,
    output logic [15:0] ethertype_next,
    output logic [7:0]  ver_ihl_next,
    output logic [7:0]  ip_proto_next,
    output logic [31:0] ip_src_next,
    output logic [31:0] ip_dst_next
);

    // Outputs are the post-beat field values so an eop beat can be folded
    // into the descriptor on the same edge that accepts it.
    logic [8*HDR_SLOTS-1:0] w_hdr_next;

    genvar gi;
    generate
        for (gi = 0; gi < HDR_SLOTS; gi++) begin : g_slot
            localparam int c_OFF  = hdr_slot_offset(gi);
            localparam int c_BEAT = c_OFF / BEAT_BYTES;
            localparam int c_LANE = c_OFF % BEAT_BYTES;

            logic [7:0] w_lane;
            logic       w_lane_ok;
            logic [7:0] w_next;
            logic [7:0] r_byte;

            assign w_lane    = in_data[63-8*c_LANE -: 8];
            assign w_lane_ok = 4'(c_LANE) < beat_bytes;

            always_comb begin
                w_next = r_byte;
                if (cap_start) begin
                    w_next = ((c_BEAT == 0) && w_lane_ok) ? w_lane : 8'h00;
                end else if (cap_en && (beat_idx == 3'(c_BEAT)) && w_lane_ok) begin
                    w_next = w_lane;
                end
            end

            always_ff @(posedge clk or negedge system_reset_n) begin
                if (!system_reset_n) begin
                    r_byte <= 8'h00;
                end else begin
                    r_byte <= w_next;
                end
            end

            assign w_hdr_next[8*(HDR_SLOTS-1-gi) +: 8] = w_next;
        end
    endgenerate

    assign {dst_mac_next, src_mac_next, ethertype_next, ver_ihl_next,
            ip_proto_next, ip_src_next, ip_dst_next} = w_hdr_next;

endmodule
`default_nettype wire

// File: rtl/eth_ipv4_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module   : eth_ipv4_hdr_parser
// Brief    : Per-packet Ethernet II / IPv4 header descriptor extraction.
// Revision : 1.0 - initial release
// ============================================================================
module eth_ipv4_hdr_parser
    import pkt_parser_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             system_reset_n,
    input  logic [63:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [2:0]       in_empty,
    input  logic             in_error,
    output logic             desc_valid,
    input  logic             desc_ready,
    output hdr_desc_t        desc,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count
);

    parser_state_t    r_state, w_state_next;
    logic [2:0]       r_beat_idx, w_beat_idx_next;
    logic [LEN_W-1:0] r_len;
    logic             r_err;
    hdr_desc_t        r_desc, w_desc_next;
    logic             r_desc_valid;
    logic [CNT_W-1:0] r_pkt_count, r_drop_count;

    logic w_accept, w_track, w_finish, w_drop, w_cap_start, w_cap_en;
    logic [3:0]       w_beat_bytes;
    logic [LEN_W-1:0] w_len_base, w_len_next;
    logic [LEN_W:0]   w_len_sum;
    logic             w_err_next, w_short;

    logic [47:0] w_dst_mac, w_src_mac;
    logic [15:0] w_ethertype;
    logic [7:0]  w_ver_ihl, w_ip_proto;
    logic [31:0] w_ip_src, w_ip_dst;
    logic        w_unused_ihl;

    assign in_ready     = !r_desc_valid || desc_ready;
    assign w_accept     = in_valid && in_ready;
    assign w_beat_bytes = in_eop ? (4'(BEAT_BYTES) - {1'b0, in_empty}) : 4'(BEAT_BYTES);

    // A sop beat always restarts the byte count, whatever state it lands in.
    assign w_len_base = in_sop ? '0 : r_len;
    assign w_len_sum  = {1'b0, w_len_base} + {{(LEN_W-3){1'b0}}, w_beat_bytes};
    assign w_len_next = w_len_sum[LEN_W] ? '1 : w_len_sum[LEN_W-1:0];
    assign w_err_next = in_error || (!in_sop && r_err);
    assign w_short    = w_len_next < LEN_W'(IPV4_MIN_HDR_END);

    always_comb begin
        w_state_next    = r_state;
        w_beat_idx_next = r_beat_idx;
        w_track         = 1'b0;
        w_finish        = 1'b0;
        w_drop          = 1'b0;
        w_cap_start     = 1'b0;
        w_cap_en        = 1'b0;
        if (w_accept) begin
            if (in_sop) begin
                w_cap_start     = 1'b1;
                w_track         = 1'b1;
                w_drop          = (r_state != IDLE);
                w_beat_idx_next = 3'd1;
                w_finish        = in_eop;
                w_state_next    = in_eop ? IDLE : HDR;
            end else begin
                case (r_state)
                    HDR: begin
                        w_cap_en        = 1'b1;
                        w_track         = 1'b1;
                        w_beat_idx_next = r_beat_idx + 3'd1;
                        if (in_eop) begin
                            w_finish     = 1'b1;
                            w_state_next = IDLE;
                        end else if (r_beat_idx == 3'd4) begin
                            w_state_next = BODY;
                        end
                    end
                    BODY: begin
                        w_track = 1'b1;
                        if (in_eop) begin
                            w_finish     = 1'b1;
                            w_state_next = IDLE;
                        end
                    end
                    default: begin
                        // Stray beats outside a packet are discarded.
                        w_state_next = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    hdr_byte_capture u_capture (
        .clk            (clk),
        .system_reset_n (system_reset_n),
        .cap_start      (w_cap_start),
        .cap_en         (w_cap_en),
        .beat_idx       (r_beat_idx),
        .beat_bytes     (w_beat_bytes),
        .in_data        (in_data),
        .dst_mac_next   (w_dst_mac),
        .src_mac_next   (w_src_mac),
        .ethertype_next (w_ethertype),
        .ver_ihl_next   (w_ver_ihl),
        .ip_proto_next  (w_ip_proto),
        .ip_src_next    (w_ip_src),
        .ip_dst_next    (w_ip_dst)
    );

    assign w_unused_ihl = ^w_ver_ihl[3:0];

    always_comb begin
        w_desc_next           = '0;
        w_desc_next.dst_mac   = w_dst_mac;
        w_desc_next.src_mac   = w_src_mac;
        w_desc_next.ethertype = w_ethertype;
        w_desc_next.ip_proto  = w_ip_proto;
        w_desc_next.ip_src    = w_ip_src;
        w_desc_next.ip_dst    = w_ip_dst;
        w_desc_next.pkt_len   = DESC_LEN_W'(w_len_next);
        w_desc_next.is_ipv4   = (w_ethertype == ETHERTYPE_IPV4) &&
                                (w_ver_ihl[7:4] == 4'd4) && !w_short;
        w_desc_next.truncated = w_short;
        w_desc_next.err       = w_err_next;
    end

    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_beat_idx   <= 3'd0;
            r_len        <= '0;
            r_err        <= 1'b0;
            r_desc       <= '0;
            r_desc_valid <= 1'b0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_track) begin
                r_beat_idx <= w_beat_idx_next;
                r_len      <= w_len_next;
                r_err      <= w_err_next;
            end
            // A finishing packet can reload while the old descriptor is consumed.
            if (w_finish) begin
                r_desc       <= w_desc_next;
                r_desc_valid <= 1'b1;
            end else if (r_desc_valid && desc_ready) begin
                r_desc_valid <= 1'b0;
            end
            if (r_desc_valid && desc_ready) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end
            if (w_drop) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign desc_valid = r_desc_valid;
    assign desc       = r_desc;
    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_eth_ipv4_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_ipv4_hdr_parser
// Brief    : Self-checking bench for eth_ipv4_hdr_parser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_ipv4_hdr_parser;
    import pkt_parser_pkg::*;

    localparam int LEN_W = 16;
    localparam int CNT_W = 32;

    typedef byte unsigned bytes_q_t[$];

    typedef struct {
        string       name;
        int          len;
        logic [15:0] etype;
        logic [7:0]  ver_ihl;
        int          err_beat;
        logic [15:0] exp_len;
        logic [47:0] exp_src_mac;
        logic [15:0] exp_etype;
        logic [7:0]  exp_proto;
        logic [31:0] exp_ip_src;
        logic [31:0] exp_ip_dst;
        bit          exp_ipv4;
        bit          exp_trunc;
        bit          exp_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             system_reset_n;
    logic [63:0]      in_data;
    logic             in_valid, in_ready, in_sop, in_eop, in_error;
    logic [2:0]       in_empty;
    logic             desc_valid, desc_ready;
    hdr_desc_t        desc;
    logic [CNT_W-1:0] pkt_count, drop_count;

    always #5 clk = ~clk;

    eth_ipv4_hdr_parser #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .system_reset_n (system_reset_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_empty       (in_empty),
        .in_error       (in_error),
        .desc_valid     (desc_valid),
        .desc_ready     (desc_ready),
        .desc           (desc),
        .pkt_count      (pkt_count),
        .drop_count     (drop_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: whole packets as byte lists.
    bytes_q_t    m_bytes;
    bit          m_in_pkt = 1'b0;
    bit          m_err = 1'b0;
    hdr_desc_t   m_exp_q[$];
    int          m_drops = 0;
    int          hs_count = 0;
    int          beats_accepted = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic hdr_desc_t model_desc();
        hdr_desc_t  d;
        logic [7:0] b [34];
        int         n;
        n = m_bytes.size();
        for (int i = 0; i < 34; i++) b[i] = (i < n) ? m_bytes[i] : 8'h00;
        d = '0;
        for (int i = 0; i < 6; i++)  d.dst_mac = {d.dst_mac[39:0], b[i]};
        for (int i = 6; i < 12; i++) d.src_mac = {d.src_mac[39:0], b[i]};
        d.ethertype = {b[12], b[13]};
        d.ip_proto  = b[23];
        d.ip_src    = {b[26], b[27], b[28], b[29]};
        d.ip_dst    = {b[30], b[31], b[32], b[33]};
        d.pkt_len   = (n > 65535) ? 16'hFFFF : 16'(n);
        d.truncated = (n < 34);
        d.is_ipv4   = (d.ethertype == 16'h0800) && (b[14][7:4] == 4'd4) && (n >= 34);
        d.err       = m_err;
        return d;
    endfunction

    function automatic void model_beat(input logic [63:0] d, input bit sop, input bit eop,
                                       input logic [2:0] emp, input bit err);
        int nb;
        nb = eop ? 8 - int'(emp) : 8;
        if (sop) begin
            if (m_in_pkt) m_drops++;
            m_bytes.delete();
            m_err    = 1'b0;
            m_in_pkt = 1'b1;
        end
        if (!m_in_pkt) return;
        for (int k = 0; k < nb; k++) m_bytes.push_back(d[63-8*k -: 8]);
        m_err = m_err | err;
        if (eop) begin
            m_exp_q.push_back(model_desc());
            m_in_pkt = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        m_exp_q.delete();
        m_bytes.delete();
        m_in_pkt = 1'b0;
        m_drops  = 0;
        hs_count = 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input bit sop, input bit eop,
                             input logic [2:0] emp, input bit err);
        bit acc;
        acc      = 1'b0;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        in_empty = emp;
        in_error = err;
        in_valid = 1'b1;
        for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) begin
            model_beat(d, sop, eop, emp, err);
            beats_accepted++;
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_accept_timeout: got no acceptance, expected in_ready within 2000 cycles");
        end
    endtask

    task automatic send_frame(input bytes_q_t fr, input int err_beat, input bit with_eop);
        int len, nb;
        len = fr.size();
        nb  = (len + 7) / 8;
        for (int bi = 0; bi < nb; bi++) begin
            logic [63:0] d;
            bit          last;
            for (int k = 0; k < 8; k++)
                d[63-8*k -: 8] = (bi*8 + k < len) ? fr[bi*8 + k] : 8'($urandom);
            last = with_eop && (bi == nb - 1);
            send_beat(d, bi == 0, last, last ? 3'(nb*8 - len) : 3'd0, bi == err_beat);
        end
    endtask

    function automatic bytes_q_t make_frame(input int len, input logic [15:0] etype, input logic [7:0] vi);
        bytes_q_t     q;
        logic [271:0] t;
        t = {48'h001122334455, 48'h66778899AABB, etype, vi, 8'h00, 16'h0028, 16'h1234,
             16'h0000, 8'h40, 8'h11, 16'h0000, 32'h0A000001, 32'h0A000002};
        for (int o = 0; o < len; o++)
            q.push_back((o < 34) ? t[271-8*o -: 8] : 8'(o*7 + 3));
        return q;
    endfunction

    task automatic drain(input string name);
        int t;
        t = 0;
        while (m_exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        n_cmp++;
        if (m_exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d descriptors outstanding, expected 0", name, m_exp_q.size());
        end
    endtask

    // Consumer-side scoreboard: every handshake is compared with the model.
    always @(negedge clk) begin
        hdr_desc_t e;
        if (system_reset_n && desc_valid && desc_ready) begin
            hs_count++;
            if (m_exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL desc_unexpected: got pkt_len %0d, expected no descriptor", desc.pkt_len);
            end else begin
                e = m_exp_q.pop_front();
                check("desc_vs_model", desc, e);
            end
        end
    end

    vec_t      vecs[8];
    hdr_desc_t snap;
    int        b0, vcnt;
    bit        rnd_done;

    initial begin
        vecs[0] = '{"ipv4_udp_60", 60, 16'h0800, 8'h45, -1, 16'd60, 48'h66778899AABB, 16'h0800, 8'h11, 32'h0A000001, 32'h0A000002, 1, 0, 0};
        vecs[1] = '{"arp_64",      64, 16'h0806, 8'h45, -1, 16'd64, 48'h66778899AABB, 16'h0806, 8'h11, 32'h0A000001, 32'h0A000002, 0, 0, 0};
        vecs[2] = '{"short_20",    20, 16'h0800, 8'h45, -1, 16'd20, 48'h66778899AABB, 16'h0800, 8'h00, 32'h0,        32'h0,        0, 1, 0};
        vecs[3] = '{"err_beat2",   60, 16'h0800, 8'h45,  2, 16'd60, 48'h66778899AABB, 16'h0800, 8'h11, 32'h0A000001, 32'h0A000002, 1, 0, 1};
        vecs[4] = '{"len_34",      34, 16'h0800, 8'h45, -1, 16'd34, 48'h66778899AABB, 16'h0800, 8'h11, 32'h0A000001, 32'h0A000002, 1, 0, 0};
        vecs[5] = '{"len_33",      33, 16'h0800, 8'h45, -1, 16'd33, 48'h66778899AABB, 16'h0800, 8'h11, 32'h0A000001, 32'h0A000000, 0, 1, 0};
        vecs[6] = '{"ver6_60",     60, 16'h0800, 8'h60, -1, 16'd60, 48'h66778899AABB, 16'h0800, 8'h11, 32'h0A000001, 32'h0A000002, 0, 0, 0};
        vecs[7] = '{"single_8",     8, 16'h0800, 8'h45,  0, 16'd8,  48'h667700000000, 16'h0000, 8'h00, 32'h0,        32'h0,        0, 1, 1};

        system_reset_n = 1'b0;
        in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_empty = '0; in_error = 1'b0; desc_ready = 1'b1;
        tick(3);
        check("rst_desc_valid", desc_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_desc", desc, '0);
        system_reset_n = 1'b1;
        tick(2);

        foreach (vecs[i]) begin
            send_frame(make_frame(vecs[i].len, vecs[i].etype, vecs[i].ver_ihl), vecs[i].err_beat, 1'b1);
            check({vecs[i].name, "_latency"}, desc_valid, 1'b1);
            check({vecs[i].name, "_dst_mac"}, desc.dst_mac, 48'h001122334455);
            check({vecs[i].name, "_src_mac"}, desc.src_mac, vecs[i].exp_src_mac);
            check({vecs[i].name, "_fields"}, {desc.ethertype, desc.ip_proto, desc.ip_src, desc.ip_dst},
                  {vecs[i].exp_etype, vecs[i].exp_proto, vecs[i].exp_ip_src, vecs[i].exp_ip_dst});
            check({vecs[i].name, "_len_flags"}, {desc.pkt_len, desc.is_ipv4, desc.truncated, desc.err},
                  {vecs[i].exp_len, vecs[i].exp_ipv4, vecs[i].exp_trunc, vecs[i].exp_err});
            tick(1);
        end
        drain("table");

        // Stray non-sop beats while idle must vanish without trace.
        send_beat(64'hDEADBEEF_01234567, 1'b0, 1'b0, 3'd0, 1'b1);
        send_beat(64'hCAFEF00D_89ABCDEF, 1'b0, 1'b1, 3'd2, 1'b0);
        send_frame(make_frame(42, 16'h0800, 8'h45), -1, 1'b1);
        check("stray_desc_len", desc.pkt_len, 16'd42);
        check("stray_desc_err", desc.err, 1'b0);
        drain("stray");

        // Aborted packet: three beats without eop, then a fresh 40-byte packet.
        send_frame(make_frame(24, 16'h0800, 8'h45), -1, 1'b0);
        send_frame(make_frame(40, 16'h0800, 8'h45), -1, 1'b1);
        check("abort_len", desc.pkt_len, 16'd40);
        check("abort_drop_count", drop_count, 1);
        drain("abort");

        // Back-pressure across two back-to-back packets.
        desc_ready = 1'b0;
        fork
            begin
                send_frame(make_frame(48, 16'h0800, 8'h45), -1, 1'b1);
                send_frame(make_frame(56, 16'h0806, 8'h45), -1, 1'b1);
            end
            begin
                vcnt = 0;
                while (!desc_valid && vcnt < 200) begin
                    @(negedge clk);
                    vcnt++;
                end
                @(negedge clk);
                check("bp_in_ready_low", in_ready, 1'b0);
                check("bp_first_len", desc.pkt_len, 16'd48);
                snap = desc;
                b0 = beats_accepted;
                repeat (20) @(negedge clk);
                check("bp_valid_held", desc_valid, 1'b1);
                check("bp_desc_stable", desc, snap);
                check("bp_input_stalled", beats_accepted, b0);
                @(posedge clk);
                #1;
                desc_ready = 1'b1;
            end
        join
        drain("backpressure");
        tick(2);
        check("bp_pkt_count", pkt_count, hs_count);

        // Randomised traffic against the reference model.
        rnd_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    bytes_q_t fr;
                    int       len;
                    len = $urandom_range(1, 130);
                    for (int o = 0; o < len; o++) fr.push_back(8'($urandom));
                    if (len > 14 && $urandom_range(0, 1) == 1) begin
                        fr[12] = 8'h08;
                        fr[13] = 8'h00;
                        fr[14] = ($urandom_range(0, 3) != 0) ? 8'h45 : 8'($urandom);
                    end
                    if ($urandom_range(0, 9) == 0)
                        send_beat({$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom), 1'b0);
                    send_frame(fr, int'($urandom_range(0, 20)), $urandom_range(0, 7) != 0);
                    tick($urandom_range(0, 2));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    desc_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        desc_ready = 1'b1;
        drain("random");
        tick(2);
        check("rnd_pkt_count", pkt_count, hs_count);
        check("rnd_drop_count", drop_count, m_drops);

        // Reset with a held descriptor, then reset mid-packet.
        desc_ready = 1'b0;
        send_frame(make_frame(60, 16'h0800, 8'h45), 1, 1'b1);
        check("prereset_valid", desc_valid, 1'b1);
        #2;
        system_reset_n = 1'b0;
        #1;
        model_reset();
        check("reset_desc_valid", desc_valid, 1'b0);
        check("reset_counters", {pkt_count, drop_count}, 64'd0);
        check("reset_in_ready", in_ready, 1'b1);
        tick(2);
        system_reset_n = 1'b1;
        desc_ready = 1'b1;
        tick(1);
        send_frame(make_frame(16, 16'h0800, 8'h45), -1, 1'b0);
        #2;
        system_reset_n = 1'b0;
        #1;
        model_reset();
        check("midpkt_reset_valid", desc_valid, 1'b0);
        tick(2);
        system_reset_n = 1'b1;
        tick(1);
        send_beat(64'h1111111111111111, 1'b0, 1'b0, 3'd0, 1'b0);
        send_beat(64'h2222222222222222, 1'b0, 1'b0, 3'd0, 1'b0);
        send_beat(64'h3333333333333333, 1'b0, 1'b1, 3'd4, 1'b0);
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (desc_valid) vcnt++;
        end
        check("postreset_no_desc", vcnt, 0);
        check("postreset_counters", {pkt_count, drop_count}, 64'd0);
        tick(1);
        send_frame(make_frame(60, 16'h0800, 8'h45), -1, 1'b1);
        check("postreset_ipv4", desc.is_ipv4, 1'b1);
        drain("postreset");
        tick(2);
        check("final_pkt_count", pkt_count, hs_count);
        check("final_drop_count", drop_count, m_drops);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
